// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staggered reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_BOARD = 2'b01;
  localparam logic [1:0] CAUSE_SW    = 2'b10;

endpackage

// File: rtl/reset_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts on the SYNC_STAGES-th clock edge.
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic [SYNC_STAGES-1:0] chain;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync_n = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_seq_mgr.sv
// Board/software reset manager: stretches the synchronised reset, then releases
// the domain resets one by one, STAGGER cycles apart, starting with channel 0.
module reset_seq_mgr
  import reset_seq_pkg::*;
#(
  parameter int               N_RST       = 3,
  parameter int               CNT_W       = 16,
  parameter logic [CNT_W-1:0] STRETCH     = '1,
  parameter int               STAGGER     = 16,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_rst_req,
  input  logic             ext_hold,
  output logic [N_RST-1:0] rst_out,
  output logic             rst_done,
  output logic [1:0]       rst_cause
);

  localparam int STG_W = (STAGGER < 1) ? 1 : $clog2(STAGGER + 1);
  localparam int IDX_W = $clog2(N_RST + 1);
  localparam logic [STG_W-1:0] STAGGER_V = STG_W'(STAGGER);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_RST - 1);

  logic rst_sync_n;

  reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (rst_sync_n)
  );

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [STG_W-1:0] stag, stag_nxt;
  logic [IDX_W-1:0] ch_idx, ch_idx_nxt;
  logic [N_RST-1:0] rst_out_nxt;
  logic             rst_done_nxt;
  logic [1:0]       rst_cause_nxt;
  logic             sw_q;
  logic             sw_rise;

  // A held request produces a single restart; a new one needs low-then-high.
  assign sw_rise = sw_rst_req & ~sw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ASSERT;
      cnt       <= STRETCH;
      stag      <= '0;
      ch_idx    <= '0;
      rst_out   <= '1;
      rst_done  <= 1'b0;
      rst_cause <= CAUSE_BOARD;
      sw_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stag      <= stag_nxt;
      ch_idx    <= ch_idx_nxt;
      rst_out   <= rst_out_nxt;
      rst_done  <= rst_done_nxt;
      rst_cause <= rst_cause_nxt;
      sw_q      <= sw_rst_req;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    stag_nxt      = stag;
    ch_idx_nxt    = ch_idx;
    rst_out_nxt   = rst_out;
    rst_done_nxt  = rst_done;
    rst_cause_nxt = rst_cause;

    if (!rst_sync_n) begin
      state_nxt    = ASSERT;
      cnt_nxt      = STRETCH;
      rst_out_nxt  = '1;
      rst_done_nxt = 1'b0;
    end else if (sw_rise) begin
      // A restart outranks any release happening on the same edge.
      state_nxt     = ASSERT;
      cnt_nxt       = STRETCH;
      rst_out_nxt   = '1;
      rst_done_nxt  = 1'b0;
      rst_cause_nxt = CAUSE_SW;
    end else begin
      unique case (state)
        ASSERT: begin
          if (ext_hold) begin
            cnt_nxt = STRETCH;
          end else if (cnt == '0) begin
            if (N_RST == 1 || STAGGER == 0) begin
              rst_out_nxt  = '0;
              rst_done_nxt = 1'b1;
              state_nxt    = RUN;
            end else begin
              rst_out_nxt[0] = 1'b0;
              ch_idx_nxt     = IDX_W'(1);
              stag_nxt       = STAGGER_V;
              state_nxt      = RELEASE;
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end

        RELEASE: begin
          // stag==1 means this edge takes it to zero, so the channel drops now.
          if (stag <= STG_W'(1)) begin
            for (int k = 0; k < N_RST; k++) begin
              if (k == int'(ch_idx)) rst_out_nxt[k] = 1'b0;
            end
            if (ch_idx == LAST_IDX) begin
              rst_done_nxt = 1'b1;
              state_nxt    = RUN;
            end else begin
              ch_idx_nxt = ch_idx + IDX_W'(1);
              stag_nxt   = STAGGER_V;
            end
          end else begin
            stag_nxt = stag - STG_W'(1);
          end
        end

        RUN: begin
          rst_out_nxt  = '0;
          rst_done_nxt = 1'b1;
        end

        default: begin
          state_nxt    = ASSERT;
          cnt_nxt      = STRETCH;
          rst_out_nxt  = '1;
          rst_done_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq_mgr.sv
// Directed bench for reset_seq_mgr: staggered release, software restart, hold, async abort.
module tb_reset_seq_mgr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       ext_hold = 1'b0;
  logic [2:0] rst_out, rst_out_z;
  logic       rst_done, rst_done_z;
  logic [1:0] rst_cause, rst_cause_z;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reset_seq_mgr #(
    .N_RST(3), .CNT_W(16), .STRETCH(16'd10), .STAGGER(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .ext_hold(ext_hold),
    .rst_out(rst_out), .rst_done(rst_done), .rst_cause(rst_cause)
  );

  reset_seq_mgr #(
    .N_RST(3), .CNT_W(16), .STRETCH(16'd10), .STAGGER(0), .SYNC_STAGES(2)
  ) dut_z (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .ext_hold(ext_hold),
    .rst_out(rst_out_z), .rst_done(rst_done_z), .rst_cause(rst_cause_z)
  );

  // Expected {rst_out, rst_done, rst_cause} when channel 0 drops on edge base, STAGGER=4.
  function automatic logic [5:0] exp_seq(int e, int base, logic [1:0] cause);
    logic [2:0] ro;
    if (e < base)          ro = 3'b111;
    else if (e < base + 4) ro = 3'b110;
    else if (e < base + 8) ro = 3'b100;
    else                   ro = 3'b000;
    return {ro, (e >= base + 8), cause};
  endfunction

  task automatic cmp(string name, int e, logic [5:0] got, logic [5:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s edge %0d: out/done/cause got %b_%b_%b expected %b_%b_%b",
               name, e, got[5:3], got[2], got[1:0], exp[5:3], exp[2], exp[1:0]);
    end
  endtask

  task automatic board_reset_cycle();
    @(negedge clk) rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk) rst_n = 1'b0;
    #1;
    cmp("reset_async", 0, {rst_out, rst_done, rst_cause}, {3'b111, 1'b0, 2'b01});
    cmp("reset_async_z", 0, {rst_out_z, rst_done_z, rst_cause_z}, {3'b111, 1'b0, 2'b01});
    repeat (5) @(negedge clk);
    cmp("reset_held", 0, {rst_out, rst_done, rst_cause}, {3'b111, 1'b0, 2'b01});
  endtask

  task automatic test_powerup();
    rst_n = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk); #1;
      cmp("powerup", e, {rst_out, rst_done, rst_cause}, exp_seq(e, 13, 2'b01));
    end
  endtask

  task automatic test_sw_pulse();
    @(negedge clk) sw_rst_req = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk); #1;
      cmp("sw_pulse", e, {rst_out, rst_done, rst_cause}, exp_seq(e, 12, 2'b10));
      sw_rst_req = 1'b0;
    end
  endtask

  task automatic test_hold();
    board_reset_cycle();
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk); #1;
      cmp("hold", e, {rst_out, rst_done, rst_cause}, exp_seq(e, 35, 2'b01));
      if (e == 4)  ext_hold = 1'b1;
      if (e == 24) ext_hold = 1'b0;
    end
    // Hold is ignored once running.
    ext_hold = 1'b1;
    for (int e = 46; e <= 48; e++) begin
      @(posedge clk); #1;
      cmp("hold_in_run", e, {rst_out, rst_done, rst_cause}, {3'b000, 1'b1, 2'b01});
    end
    ext_hold = 1'b0;
  endtask

  task automatic test_midreset();
    @(negedge clk) sw_rst_req = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk); #1;
      cmp("mid_sw", e, {rst_out, rst_done, rst_cause}, exp_seq(e, 12, 2'b10));
      sw_rst_req = 1'b0;
    end
    @(negedge clk) rst_n = 1'b0;
    #1;
    cmp("mid_abort", 0, {rst_out, rst_done, rst_cause}, {3'b111, 1'b0, 2'b01});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk); #1;
      cmp("mid_repeat", e, {rst_out, rst_done, rst_cause}, exp_seq(e, 13, 2'b01));
    end
  endtask

  task automatic test_stagger_zero();
    board_reset_cycle();
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      cmp("stagger_zero", e, {rst_out_z, rst_done_z, rst_cause_z},
          (e < 13) ? {3'b111, 1'b0, 2'b01} : {3'b000, 1'b1, 2'b01});
    end
    repeat (8) @(posedge clk);
    #1;
    cmp("stagger_main_run", 0, {rst_out, rst_done, rst_cause}, {3'b000, 1'b1, 2'b01});
  endtask

  task automatic test_sw_held();
    @(negedge clk) sw_rst_req = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      cmp("sw_held", e, {rst_out, rst_done, rst_cause}, exp_seq(e, 12, 2'b10));
    end
    sw_rst_req = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      cmp("sw_low", e, {rst_out, rst_done, rst_cause}, {3'b000, 1'b1, 2'b10});
    end
    sw_rst_req = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk); #1;
      cmp("sw_second", e, {rst_out, rst_done, rst_cause}, exp_seq(e, 12, 2'b10));
    end
    sw_rst_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_sw_pulse();
    test_hold();
    test_midreset();
    test_stagger_zero();
    test_sw_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
